keccak_nonce_scheduler: RTL and testbench
=========================================

# keccak_nonce_scheduler

Work dispatcher and result collector for the fully pipelined `keccak256_80` hasher. It accepts one job at a time: a 640-bit header template, a start nonce, a nonce count and a 64-bit target. It then issues one header per clock into the hasher with the nonce substituted. Returned hashes are matched to their nonces with a valid delay line. Hits are queued in a small result FIFO, so the host never tracks pipeline latency.

## Interface

**Parameters**
- `LATENCY`, default 98: cycles from `pipe_data` change to the corresponding `pipe_hash`. Must equal the hasher's latency, which is 98 for `keccak256_80`.
- `FIFO_DEPTH`, default 4: number of result FIFO entries; power of 2, ≥2.

**Ports**
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `work_valid` in 1: job offer.
- `work_ready` out 1: high only in IDLE.
- `work_header` in 640: header template; bits [31:0] are ignored and replaced by the nonce.
- `work_nonce` in 32: first nonce.
- `work_count` in 32: number of nonces; 0 means empty job.
- `work_target` in 64: hit if `pipe_hash[255:192] <= target` (unsigned).
- `abort` in 1: cancel the current job.
- `pipe_data` out 640: to hasher `data`; registered.
- `pipe_hash` in 256: from hasher `hash`.
- `res_valid` out 1: result FIFO not empty.
- `res_ready` in 1: result pop.
- `res_nonce` out 32: nonce of the FIFO head.
- `res_hash` out 64: `pipe_hash[255:192]` of the FIFO head.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at job completion.
- `overflow` out 1: sticky; a hit was dropped because the FIFO was full. Cleared only by reset or by accepting a new job.

## Operation

**States**
- **IDLE**
  - Accept on `work_valid & work_ready`.
  - Latch header, target and count.
  - Set `issue_nonce` and `ret_nonce` to `work_nonce`.
  - Clear `overflow`.
  - Go to RUN, or to DRAIN if `work_count == 0`.
- **RUN**, each cycle:
  - `pipe_data <= {header[639:32], issue_nonce}`.
  - Push 1 into the valid delay line.
  - `issue_nonce` increments mod 2^32.
  - The remaining count decrements.
  - After the cycle that issues the last nonce, go to DRAIN.
- **DRAIN**
  - Shift 0 into the delay line.
  - `pipe_data` holds its last value.
  - When the delay line is all-zero and no compare is pending, pulse `done` and go to IDLE.

**Result matching**
- The delay line is `LATENCY` bits. Its output bit marks `pipe_hash` as valid in that cycle.
- On a valid output:
  - Register `{ret_nonce, pipe_hash[255:192], hit}` into the compare stage.
  - `ret_nonce` increments mod 2^32.
- The nonce is reconstructed from issue order; no per-nonce storage is kept.
- A hit from the compare stage is pushed to the FIFO the following cycle.
- If the FIFO is full and no pop happens in that cycle, drop the hit and set `overflow`.
- A simultaneous push and pop on a full FIFO succeeds.
- The FIFO is first-word-fall-through: `res_*` are valid while `res_valid` is high.
- Results survive job completion and new-job accept; only reset clears the FIFO.

**Abort**
- Takes effect in any non-IDLE state.
- Clears the delay line and the compare stage; in-flight hashes are discarded.
- Goes to IDLE next cycle with no `done` pulse.
- FIFO contents are kept.
- `abort` in IDLE is ignored.
- If `abort` coincides with a work accept, the accept wins.

**Wrap**
- Start `0xFFFFFFFE` with count 4 issues FFFFFFFE, FFFFFFFF, 00000000, 00000001.

## Timing

**Reset values**
- `pipe_data` = 0.
- `work_ready` = 0 during reset, 1 after (IDLE).
- `res_valid`, `busy`, `done`, `overflow` = 0.
- Delay line and FIFO empty.

**Latencies** (accept edge = E)
- The first nonce appears on `pipe_data` after edge E+1.
- Nonce k (0-based) is on `pipe_data` during cycle E+1+k.
- Its hash is sampled at edge E+1+k+LATENCY.
- A hit reaches `res_valid` 2 cycles after sampling.
- `done` is high during the cycle after the last compare-stage FIFO push opportunity. For count N that is cycle E+N+LATENCY+3.
- `work_ready` rises the cycle after `done`.
- `busy` is high from E+1 through the `done` cycle inclusive.

**Throughput**
- One nonce per clock; no bubbles in RUN.

## Test plan

- **Reference hit.** Job: start 0, count 8, target `0xFFFFFFFFFFFFFFFF`, with a stub hasher (pure `LATENCY` delay, hash = data). Expect:
  - 8 pops with `res_nonce` 0..7 in order;
  - `done` at E+8+98+3;
  - no `overflow`.
- **Target filter.** Target 0, real `keccak256_80`, count 16. Expect:
  - zero results;
  - exactly one `done`;
  - `busy` low afterwards.
- **Overflow.** Target all-ones, count 10, FIFO depth 4, `res_ready` held 0. Expect:
  - 4 entries (nonces 0..3);
  - `overflow` = 1;
  - entries kept after `done`.
- **Abort mid-run.** Assert `abort` 20 cycles after accept. Expect:
  - IDLE next cycle;
  - no `done` pulse;
  - no results for the next 200 cycles;
  - a new job accepted afterwards works normally.
- **Wrap and empty job.**
  - Start `0xFFFFFFFE`, count 4, target all-ones: `res_nonce` sequence FFFFFFFE, FFFFFFFF, 0, 1.
  - Count 0: `done` pulses with no results and no issue.
- **Async reset mid-run.** Assert `reset` between edges during DRAIN. Expect all outputs at reset values immediately, before the next edge.

Source files
------------

// File: rtl/keccak_nonce_scheduler_if.sv
// Bundle between the nonce scheduler and its surroundings: the host work
// channel, the result FIFO read port, the hasher pipeline port and the
// job status flags.
interface keccak_nonce_scheduler_if;
  logic         work_valid;
  logic         work_ready;
  logic [639:0] work_header;
  logic [31:0]  work_nonce;
  logic [31:0]  work_count;
  logic [63:0]  work_target;
  logic         abort;

  logic [639:0] pipe_data;
  logic [255:0] pipe_hash;

  logic         res_valid;
  logic         res_ready;
  logic [31:0]  res_nonce;
  logic [63:0]  res_hash;

  logic         busy;
  logic         done;
  logic         overflow;

  // Host plus hasher side of the bundle
  modport master (
    output work_valid, work_header, work_nonce, work_count, work_target,
           abort, pipe_hash, res_ready,
    input  work_ready, pipe_data, res_valid, res_nonce, res_hash,
           busy, done, overflow
  );

  // Scheduler side of the bundle
  modport slave (
    input  work_valid, work_header, work_nonce, work_count, work_target,
           abort, pipe_hash, res_ready,
    output work_ready, pipe_data, res_valid, res_nonce, res_hash,
           busy, done, overflow
  );
endinterface

// File: rtl/keccak_nonce_scheduler.sv
// Job dispatcher and result collector for a fully pipelined keccak hasher.
// One header per clock is issued with the nonce substituted into bits
// [31:0]. Returned hashes are paired with nonces by issue order through a
// valid delay line, filtered against the target and queued in a small
// first-word-fall-through result FIFO.
module keccak_nonce_scheduler #(
  parameter int LATENCY    = 98,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  keccak_nonce_scheduler_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_next;

  logic accept, issue, abort_now;
  logic last_issue, pipeline_empty;

  logic [607:0] header_q;
  logic [63:0]  target_q;
  logic [31:0]  remain_q;
  logic [31:0]  issue_nonce;
  logic [31:0]  ret_nonce;

  logic               pipe_valid;
  logic [LATENCY-1:0] valid_line;
  logic               hash_valid;

  logic        cmp_valid;
  logic        cmp_hit;
  logic [31:0] cmp_nonce;
  logic [63:0] cmp_hash;

  logic [31:0]  fifo_nonce [FIFO_DEPTH];
  logic [63:0]  fifo_hash  [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic fifo_full, fifo_empty, push_req, push, pop;

  assign hash_valid     = valid_line[LATENCY-1];
  assign pipeline_empty = ~pipe_valid & ~(|valid_line) & ~cmp_valid;
  assign last_issue     = (remain_q == 32'd1);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    abort_now  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.work_valid) begin
          accept     = 1'b1;
          state_next = (bus.work_count == 32'd0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          abort_now  = 1'b1;
          state_next = IDLE;
        end else begin
          issue = 1'b1;
          if (last_issue) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          abort_now  = 1'b1;
          state_next = IDLE;
        end else if (pipeline_empty) begin
          state_next = DONE;
        end
      end
      DONE: begin
        abort_now  = bus.abort;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.work_ready = (state == IDLE) & ~reset;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);

  // Job registers, nonce counters and the registered hasher input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      header_q      <= '0;
      target_q      <= '0;
      remain_q      <= '0;
      issue_nonce   <= '0;
      ret_nonce     <= '0;
      bus.pipe_data <= '0;
      pipe_valid    <= 1'b0;
    end else begin
      pipe_valid <= issue;
      if (issue) begin
        bus.pipe_data <= {header_q, issue_nonce};
        issue_nonce   <= issue_nonce + 32'd1;
        remain_q      <= remain_q - 32'd1;
      end
      if (hash_valid && !abort_now) ret_nonce <= ret_nonce + 32'd1;
      if (accept) begin
        header_q    <= bus.work_header[639:32];
        target_q    <= bus.work_target;
        remain_q    <= bus.work_count;
        issue_nonce <= bus.work_nonce;
        ret_nonce   <= bus.work_nonce;
      end
    end
  end

  // Valid delay line tracking which hasher outputs belong to issued nonces
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          valid_line <= '0;
    else if (abort_now) valid_line <= '0;
    else                valid_line <= {valid_line[LATENCY-2:0], pipe_valid};
  end

  // Compare stage: pair the returning hash with its reconstructed nonce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_valid <= 1'b0;
      cmp_hit   <= 1'b0;
      cmp_nonce <= '0;
      cmp_hash  <= '0;
    end else if (abort_now) begin
      cmp_valid <= 1'b0;
      cmp_hit   <= 1'b0;
    end else begin
      cmp_valid <= hash_valid;
      if (hash_valid) begin
        cmp_nonce <= ret_nonce;
        cmp_hash  <= bus.pipe_hash[255:192];
        cmp_hit   <= (bus.pipe_hash[255:192] <= target_q);
      end
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = ~fifo_empty & bus.res_ready;
  assign push_req   = cmp_valid & cmp_hit & ~abort_now;
  assign push       = push_req & (~fifo_full | pop);

  // Result FIFO storage; a full FIFO still accepts a push when popped
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_nonce[wr_ptr[PTR_W-1:0]] <= cmp_nonce;
      fifo_hash[wr_ptr[PTR_W-1:0]]  <= cmp_hash;
    end
  end

  // Result FIFO pointers, kept across jobs and cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow flag, cleared when a new job is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              bus.overflow <= 1'b0;
    else if (accept)                        bus.overflow <= 1'b0;
    else if (push_req && fifo_full && !pop) bus.overflow <= 1'b1;
  end

  assign bus.res_valid = ~fifo_empty;
  assign bus.res_nonce = fifo_nonce[rd_ptr[PTR_W-1:0]];
  assign bus.res_hash  = fifo_hash[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_keccak_nonce_scheduler.sv
// Directed bench for keccak_nonce_scheduler. A stub hasher stands in for
// the real one: a pure LATENCY-register delay whose 64-bit hash top word
// is pipe_data[63:0], i.e. {header[63:32], nonce}, so hits and their
// hash values are easy to compute by hand.
module tb_keccak_nonce_scheduler;
  localparam int LATENCY    = 98;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic reset;

  keccak_nonce_scheduler_if bus();

  keccak_nonce_scheduler #(.LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Stub hasher: data in, same data out LATENCY edges later
  logic [63:0] stub_line [LATENCY];
  always_ff @(posedge clk) begin
    stub_line[0] <= bus.pipe_data[63:0];
    for (int i = 1; i < LATENCY; i++) stub_line[i] <= stub_line[i-1];
  end
  assign bus.pipe_hash = {stub_line[LATENCY-1], 192'b0};

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0]  got_nonce [$];
  logic [63:0]  got_hash  [$];
  int           done_cnt, done_cyc, first_res_cyc;
  logic [31:0]  pipe_seen [8];
  logic [639:0] pipe_at_1;
  logic         busy_at_done, ready_at_done, ready_after_done, busy_after_done;
  logic         ready_after_abort, busy_after_abort, ovf_at_1;
  logic [639:0] hdr_v, exp_v;

  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  // Compare one observed value against its expected value
  task automatic checkOutput(input string tag, input logic [639:0] actual,
                             input logic [639:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [639:0] make_hdr(input logic [31:0] hi);
    return {{18{32'h1234_5678}}, hi, 32'hDEAD_BEEF};
  endfunction

  // Offer one job, then watch it cycle by cycle; cycle 0 follows the accept edge
  task automatic applyStimulus(input logic [639:0] hdr, input logic [31:0] start,
                               input logic [31:0] count, input logic [63:0] target,
                               input logic ready, input int abort_at,
                               input int max_cycles);
    int wait_cnt;
    got_nonce.delete();
    got_hash.delete();
    done_cnt      = 0;
    done_cyc      = -1;
    first_res_cyc = -1;
    bus.res_ready   = ready;
    bus.work_header = hdr;
    bus.work_nonce  = start;
    bus.work_count  = count;
    bus.work_target = target;
    bus.work_valid  = 1'b1;
    wait_cnt = 0;
    while (!bus.work_ready && wait_cnt < 10) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    if (!bus.work_ready) checkOutput("accept_wait", bus.work_ready, 1);
    @(posedge clk); #1;
    bus.work_valid = 1'b0;
    for (int cyc = 1; cyc <= max_cycles; cyc++) begin
      @(posedge clk); #1;
      bus.abort = 1'b0;
      if (cyc == 1) begin
        pipe_at_1 = bus.pipe_data;
        ovf_at_1  = bus.overflow;
      end
      if (cyc <= 8) pipe_seen[cyc-1] = bus.pipe_data[31:0];
      if (bus.res_valid && bus.res_ready) begin
        got_nonce.push_back(bus.res_nonce);
        got_hash.push_back(bus.res_hash);
        if (first_res_cyc < 0) first_res_cyc = cyc;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc      = cyc;
        busy_at_done  = bus.busy;
        ready_at_done = bus.work_ready;
      end
      if (abort_at > 0 && cyc == abort_at + 1) begin
        ready_after_abort = bus.work_ready;
        busy_after_abort  = bus.busy;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        ready_after_done = bus.work_ready;
        busy_after_done  = bus.busy;
      end
      if (cyc == abort_at) bus.abort = 1'b1;
      if (done_cyc > 0 && cyc >= done_cyc + 2 && abort_at == 0) break;
    end
    bus.res_ready = 1'b0;
  endtask

  // Pop everything currently held in the result FIFO
  task automatic pop_all();
    got_nonce.delete();
    got_hash.delete();
    bus.res_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (!bus.res_valid) break;
      got_nonce.push_back(bus.res_nonce);
      got_hash.push_back(bus.res_hash);
      @(posedge clk); #1;
    end
    bus.res_ready = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.work_valid  = 1'b0;
    bus.work_header = '0;
    bus.work_nonce  = '0;
    bus.work_count  = '0;
    bus.work_target = '0;
    bus.abort       = 1'b0;
    bus.res_ready   = 1'b0;
    #2;
    checkOutput("rst_work_ready", bus.work_ready, 0);
    checkOutput("rst_pipe_data",  bus.pipe_data, 0);
    checkOutput("rst_res_valid",  bus.res_valid, 0);
    checkOutput("rst_busy",       bus.busy, 0);
    checkOutput("rst_done",       bus.done, 0);
    checkOutput("rst_overflow",   bus.overflow, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("ready_after_reset", bus.work_ready, 1);

    // Reference job: 8 nonces from 0, everything hits
    hdr_v = make_hdr(32'h0);
    applyStimulus(hdr_v, 32'h0, 32'd8, ALL_ONES, 1'b1, 0, 200);
    exp_v = {hdr_v[639:32], 32'h0};
    checkOutput("ref_first_pipe", pipe_at_1, exp_v);
    checkOutput("ref_count", got_nonce.size(), 8);
    for (int i = 0; i < 8 && i < got_nonce.size(); i++) begin
      checkOutput($sformatf("ref_nonce%0d", i), got_nonce[i], i);
      checkOutput($sformatf("ref_hash%0d", i), got_hash[i], i);
    end
    checkOutput("ref_first_res_cyc", first_res_cyc, 101);
    checkOutput("ref_done_cnt", done_cnt, 1);
    checkOutput("ref_done_cyc", done_cyc, 8 + LATENCY + 3);
    checkOutput("ref_busy_at_done", busy_at_done, 1);
    checkOutput("ref_ready_at_done", ready_at_done, 0);
    checkOutput("ref_ready_after", ready_after_done, 1);
    checkOutput("ref_busy_after", busy_after_done, 0);
    checkOutput("ref_overflow", bus.overflow, 0);

    // Target filter: hashes 0x1_xxxxxxxx never meet target 0
    applyStimulus(make_hdr(32'h1), 32'h0, 32'd16, 64'h0, 1'b1, 0, 200);
    checkOutput("filt_none_count", got_nonce.size(), 0);
    checkOutput("filt_none_done", done_cnt, 1);
    checkOutput("filt_none_busy_after", busy_after_done, 0);

    // Equal-to-target boundary: only nonce 0 gives hash 0
    applyStimulus(make_hdr(32'h0), 32'h0, 32'd16, 64'h0, 1'b1, 0, 200);
    checkOutput("filt_eq_count", got_nonce.size(), 1);
    if (got_nonce.size() > 0) checkOutput("filt_eq_nonce", got_nonce[0], 0);

    // Partial filter: nonces 3..8 against target 5 keeps 3, 4, 5
    applyStimulus(make_hdr(32'h0), 32'd3, 32'd6, 64'd5, 1'b1, 0, 200);
    checkOutput("filt_part_count", got_nonce.size(), 3);
    for (int i = 0; i < 3 && i < got_nonce.size(); i++)
      checkOutput($sformatf("filt_part_nonce%0d", i), got_nonce[i], 3 + i);

    // Overflow: 10 hits into a 4-deep FIFO with nobody popping
    applyStimulus(make_hdr(32'h0), 32'h0, 32'd10, ALL_ONES, 1'b0, 0, 200);
    checkOutput("ovf_done_cnt", done_cnt, 1);
    checkOutput("ovf_flag", bus.overflow, 1);
    checkOutput("ovf_kept_valid", bus.res_valid, 1);
    checkOutput("ovf_kept_head", bus.res_nonce, 0);
    pop_all();
    checkOutput("ovf_pop_count", got_nonce.size(), FIFO_DEPTH);
    for (int i = 0; i < FIFO_DEPTH && i < got_nonce.size(); i++)
      checkOutput($sformatf("ovf_nonce%0d", i), got_nonce[i], i);
    checkOutput("ovf_empty_after_pop", bus.res_valid, 0);
    checkOutput("ovf_sticky", bus.overflow, 1);

    // Abort 20 cycles into a 50-nonce job, then watch for 200 more cycles
    applyStimulus(make_hdr(32'h0), 32'h0, 32'd50, ALL_ONES, 1'b1, 20, 220);
    checkOutput("abort_ovf_cleared", ovf_at_1, 0);
    checkOutput("abort_idle_ready", ready_after_abort, 1);
    checkOutput("abort_idle_busy", busy_after_abort, 0);
    checkOutput("abort_no_done", done_cnt, 0);
    checkOutput("abort_no_results", got_nonce.size(), 0);

    // A normal job straight after the abort
    applyStimulus(make_hdr(32'h0), 32'd100, 32'd3, ALL_ONES, 1'b1, 0, 200);
    checkOutput("post_abort_count", got_nonce.size(), 3);
    for (int i = 0; i < 3 && i < got_nonce.size(); i++)
      checkOutput($sformatf("post_abort_nonce%0d", i), got_nonce[i], 100 + i);
    checkOutput("post_abort_done_cyc", done_cyc, 3 + LATENCY + 3);

    // Nonce wrap across 2^32
    applyStimulus(make_hdr(32'h0), 32'hFFFF_FFFE, 32'd4, ALL_ONES, 1'b1, 0, 200);
    checkOutput("wrap_pipe0", pipe_seen[0], 32'hFFFF_FFFE);
    checkOutput("wrap_pipe1", pipe_seen[1], 32'hFFFF_FFFF);
    checkOutput("wrap_pipe2", pipe_seen[2], 32'h0000_0000);
    checkOutput("wrap_pipe3", pipe_seen[3], 32'h0000_0001);
    checkOutput("wrap_count", got_nonce.size(), 4);
    if (got_nonce.size() == 4) begin
      checkOutput("wrap_res0", got_nonce[0], 32'hFFFF_FFFE);
      checkOutput("wrap_res1", got_nonce[1], 32'hFFFF_FFFF);
      checkOutput("wrap_res2", got_nonce[2], 32'h0000_0000);
      checkOutput("wrap_res3", got_nonce[3], 32'h0000_0001);
      checkOutput("wrap_hash3", got_hash[3], 64'h1);
    end

    // Empty job: done pulse, no issue, no results
    applyStimulus(make_hdr(32'h7), 32'h55, 32'd0, ALL_ONES, 1'b1, 0, 50);
    exp_v = {hdr_v[639:32], 32'h1};
    checkOutput("empty_done_cnt", done_cnt, 1);
    checkOutput("empty_done_cyc", done_cyc, 1);
    checkOutput("empty_no_results", got_nonce.size(), 0);
    checkOutput("empty_pipe_held", pipe_at_1, exp_v);
    checkOutput("empty_pipe_after", bus.pipe_data, exp_v);

    // Asynchronous reset in the middle of DRAIN
    applyStimulus(make_hdr(32'h0), 32'h0, 32'd200, ALL_ONES, 1'b0, 0, 250);
    checkOutput("pre_rst_busy", bus.busy, 1);
    checkOutput("pre_rst_res_valid", bus.res_valid, 1);
    checkOutput("pre_rst_overflow", bus.overflow, 1);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_pipe_data", bus.pipe_data, 0);
    checkOutput("mid_rst_work_ready", bus.work_ready, 0);
    checkOutput("mid_rst_busy", bus.busy, 0);
    checkOutput("mid_rst_done", bus.done, 0);
    checkOutput("mid_rst_res_valid", bus.res_valid, 0);
    checkOutput("mid_rst_overflow", bus.overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_ready", bus.work_ready, 1);
    checkOutput("post_rst_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
